cpu_sequencer: RTL

Multicycle control sequencer for the single-issue datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and drives one-hot stage strobes, including the register-file read and write strobes consumed by iDecode. MEMORY and WRITEBACK are skipped when the control signals from the decode stage show they are not needed. The block also handles the data-memory ready handshake, HALT detection, error reporting, and instruction and cycle counters.

---
 rtl/cpu_sequencer_pkg.sv | 30 +++
 rtl/cpu_sequencer_if.sv | 36 +++
 rtl/cpu_sequencer_sat_counter.sv | 28 ++
 rtl/cpu_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multicycle control sequencer: state and error
// encodings plus the default HALT opcode.
package cpu_sequencer_pkg;

    localparam int          OPC_W           = 11;
    localparam logic [10:0] DEF_HALT_OPCODE = 11'h7FF;

    typedef enum logic [2:0] {
        STATE_IDLE      = 3'd0,
        STATE_FETCH     = 3'd1,
        STATE_DECODE    = 3'd2,
        STATE_EXECUTE   = 3'd3,
        STATE_MEMORY    = 3'd4,
        STATE_WRITEBACK = 3'd5,
        STATE_HALT      = 3'd6,
        STATE_ILLEGAL   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_MEM_TIMEOUT  = 2'd1,
        ERR_ILLEGAL_CTRL = 2'd2,
        ERR_RSVD         = 2'd3
    } err_e;

    function automatic logic is_busy(input state_e s);
        return (s != STATE_IDLE) && (s != STATE_HALT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/strobe bundle between the decode stage, data memory and the sequencer.
interface cpu_sequencer_if #(parameter int CNT_W = 32);
    import cpu_sequencer_pkg::*;

    logic             start;
    logic [OPC_W-1:0] opcode;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_ready;
    logic             fetch_en;
    logic             read_en;
    logic             exec_en;
    logic             mem_en;
    logic             write_en;
    logic             pc_en;
    logic [2:0]       state;
    logic             busy;
    logic             halted;
    logic [1:0]       err;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, opcode, mem_read, mem_write, reg_write, mem_ready,
        input  fetch_en, read_en, exec_en, mem_en, write_en, pc_en,
               state, busy, halted, err, instr_count, cycle_count
    );

    modport slave (
        input  start, opcode, mem_read, mem_write, reg_write, mem_ready,
        output fetch_en, read_en, exec_en, mem_en, write_en, pc_en,
               state, busy, halted, err, instr_count, cycle_count
    );

endinterface

// File: rtl/cpu_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module cpu_sequencer_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory
// handshake timeout, HALT detection, error code and saturating counters.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [10:0] HALT_OPCODE = DEF_HALT_OPCODE,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    cpu_sequencer_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    state_e            state_q, state_d;
    err_e              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pc_en_s;
    logic              clr_s;
    logic              busy_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            err_q   <= ERR_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wait_d  = wait_q;
        pc_en_s = 1'b0;
        clr_s   = 1'b0;
        case (state_q)
            STATE_IDLE, STATE_HALT: begin
                if (bus.start) begin
                    state_d = STATE_FETCH;
                    err_d   = ERR_NONE;
                    clr_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            STATE_FETCH: state_d = STATE_DECODE;
            STATE_DECODE: begin
                if (bus.opcode == HALT_OPCODE) begin
                    state_d = STATE_HALT;
                end else begin
                    state_d = STATE_EXECUTE;
                end
            end
            STATE_EXECUTE: begin
                wait_d = '0;
                if (bus.mem_read && bus.mem_write) begin
                    state_d = STATE_HALT;
                    err_d   = ERR_ILLEGAL_CTRL;
                end else if (bus.mem_read || bus.mem_write) begin
                    state_d = STATE_MEMORY;
                end else if (bus.reg_write) begin
                    state_d = STATE_WRITEBACK;
                end else begin
                    state_d = STATE_FETCH;
                    pc_en_s = 1'b1;
                end
            end
            STATE_MEMORY: begin
                // mem_ready takes priority over a timeout in the same cycle
                if (bus.mem_ready) begin
                    if (bus.reg_write) begin
                        state_d = STATE_WRITEBACK;
                    end else begin
                        state_d = STATE_FETCH;
                        pc_en_s = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = STATE_HALT;
                    err_d   = ERR_MEM_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            STATE_WRITEBACK: begin
                state_d = STATE_FETCH;
                pc_en_s = 1'b1;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    assign busy_s = is_busy(state_q);

    cpu_sequencer_sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .inc   (pc_en_s),
        .count (bus.instr_count)
    );

    cpu_sequencer_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .inc   (busy_s),
        .count (bus.cycle_count)
    );

    assign bus.fetch_en = (state_q == STATE_FETCH);
    assign bus.read_en  = (state_q == STATE_DECODE);
    assign bus.exec_en  = (state_q == STATE_EXECUTE);
    assign bus.mem_en   = (state_q == STATE_MEMORY);
    assign bus.write_en = (state_q == STATE_WRITEBACK);
    assign bus.pc_en    = pc_en_s;
    assign bus.state    = state_q;
    assign bus.busy     = busy_s;
    assign bus.halted   = (state_q == STATE_HALT);
    assign bus.err      = err_q;

endmodule
